byte_lane_ram: RTL and testbench

Parametrised, synchronous, byte-sliced RAM. It is the clocked successor to the paired 8-bit asynchronous RAM banks, which were combined externally into a 16-bit word. It provides LANES lanes of LANE_W bits behind one shared address, with per-lane write enables, a registered read with a valid strobe, a ready handshake, and a hardware clear sweep after reset. It sits between a word-oriented master and on-chip storage, and it replaces the externally stitched RAM pair.

---
 rtl/byte_lane_ram.sv | 143 ++++++++++++++
 tb/tb_byte_lane_ram.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/byte_lane_ram.sv
// byte_lane_ram
// Synchronous byte-sliced RAM. It has LANES lanes of LANE_W bits behind one
// shared word address. Writes are masked per lane. Reads are registered and
// flagged by an rvalid pulse. A ready handshake holds off requests while an
// optional clear sweep initialises every word after reset.
//
// Ports:
//   clk       - single clock, all state changes on the rising edge
//   rst_n     - asynchronous active-low reset
//   cs        - request strobe
//   rw        - 1 = read, 0 = write
//   addr      - word address (AW bits)
//   wdata     - write data, lane i is wdata[i*LANE_W +: LANE_W]
//   be        - per-lane write enable
//   ready     - high when a request is accepted this cycle
//   rdata     - registered read data, holds until the next read result
//   rvalid    - one-cycle pulse marking a new rdata value
//   init_done - clear sweep finished (or skipped), high until next reset
module byte_lane_ram #(
    parameter int                LANES    = 2,
    parameter int                LANE_W   = 8,
    parameter int                AW       = 10,
    parameter bit                INIT_EN  = 1'b1,
    parameter logic [LANE_W-1:0] INIT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs,
    input  logic                    rw,
    input  logic [AW-1:0]           addr,
    input  logic [LANES*LANE_W-1:0] wdata,
    input  logic [LANES-1:0]        be,
    output logic                    ready,
    output logic [LANES*LANE_W-1:0] rdata,
    output logic                    rvalid,
    output logic                    init_done
);

    localparam int DW    = LANES * LANE_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   sweep_cnt;
    logic [AW-1:0]   sweep_cnt_nxt;
    logic            sweep_we;
    logic            accept;
    logic            rd_pend;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   mem [DEPTH];

    // ready and init_done come only from the state register, so no input
    // has a combinational path to an output.
    assign ready     = (state == RUN);
    assign init_done = (state == RUN);
    assign accept    = cs && ready;

    // Next-state logic. The sweep writes one word per cycle and leaves INIT
    // on the edge that writes the last address. The counter stops there
    // instead of wrapping.
    always_comb begin
        state_nxt     = state;
        sweep_cnt_nxt = sweep_cnt;
        sweep_we      = 1'b0;
        case (state)
            INIT: begin
                if (INIT_EN) begin
                    sweep_we = 1'b1;
                    if (sweep_cnt == {AW{1'b1}}) begin
                        state_nxt = RUN;
                    end else begin
                        sweep_cnt_nxt = sweep_cnt + AW'(1);
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // State and sweep counter registers. Reset restarts the sweep at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sweep_cnt <= sweep_cnt_nxt;
        end
    end

    // Storage array. It has no reset. While rst_n is held low, the sweep
    // logic keeps writing INIT_VAL to address 0. That word is cleared by the
    // sweep anyway, so this does not matter. With INIT_EN=0, sweep_we never
    // fires. Sweep writes and requests never overlap, because requests are
    // only accepted in RUN.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_cnt] <= {LANES{INIT_VAL}};
        end else if (accept && !rw) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Two-step read. The accepting edge captures the address. The following
    // edge loads rdata and raises rvalid. A reset between the two edges
    // drops the pending read, so a cancelled read never pulses rvalid.
    // rdata is loaded only by a read result, so it holds through idle cycles
    // and writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            rd_addr <= '0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            rd_pend <= accept && rw;
            if (accept && rw) begin
                rd_addr <= addr;
            end
            rvalid <= rd_pend;
            if (rd_pend) begin
                rdata <= mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_byte_lane_ram.sv
// tb_byte_lane_ram
// Self-checking bench for byte_lane_ram (LANES=2, LANE_W=8, AW=4).
// dut runs with the clear sweep enabled. dut0 is built with INIT_EN=0.
// Expected read data for dut is taken from a bench memory model when a read
// is driven, and checked against rdata when rvalid is seen.
module tb_byte_lane_ram;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic        rw;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready;
    logic [15:0] rdata;
    logic        rvalid;
    logic        init_done;

    logic        rst0_n;
    logic        cs0;
    logic        rw0;
    logic [3:0]  addr0;
    logic [15:0] wdata0;
    logic [1:0]  be0;
    logic        ready0;
    logic [15:0] rdata0;
    logic        rvalid0;
    logic        init_done0;

    int          compared;
    int          mismatched;
    logic [15:0] model_mem [16];
    bit          model_ready;
    logic [15:0] sb [$];

    byte_lane_ram #(
        .LANES(2), .LANE_W(8), .AW(4), .INIT_EN(1'b1), .INIT_VAL(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .rw(rw), .addr(addr),
        .wdata(wdata), .be(be), .ready(ready), .rdata(rdata),
        .rvalid(rvalid), .init_done(init_done)
    );

    byte_lane_ram #(
        .LANES(2), .LANE_W(8), .AW(4), .INIT_EN(1'b0), .INIT_VAL(8'h00)
    ) dut0 (
        .clk(clk), .rst_n(rst0_n), .cs(cs0), .rw(rw0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ready(ready0), .rdata(rdata0),
        .rvalid(rvalid0), .init_done(init_done0)
    );

    // 10 time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drives one cycle of stimulus on dut, starting just after a negedge.
    // The bench memory model is updated, and for a read that will be
    // accepted, the expected data is queued.
    task automatic applyStimulus(input bit c, input bit r, input logic [3:0] a,
                                 input logic [15:0] wd, input logic [1:0] b);
        cs    = c;
        rw    = r;
        addr  = a;
        wdata = wd;
        be    = b;
        if (c && model_ready) begin
            if (r) begin
                sb.push_back(model_mem[a]);
            end else begin
                if (b[0]) model_mem[a][7:0]  = wd[7:0];
                if (b[1]) model_mem[a][15:8] = wd[15:8];
            end
        end
        @(negedge clk);
    endtask

    // Scoreboard side: every rvalid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rvalid) begin
            if (sb.size() == 0) begin
                checkOutput("rvalid_unexpected", {31'b0, rvalid}, 32'h0);
            end else begin
                checkOutput("read_data", {16'b0, rdata}, {16'b0, sb.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        model_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        rst_n  = 1'b0;
        rst0_n = 1'b0;
        cs = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be = '0;
        cs0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_ready", {31'b0, ready}, 32'h0);
        checkOutput("rst_rvalid", {31'b0, rvalid}, 32'h0);
        checkOutput("rst_rdata", {16'b0, rdata}, 32'h0);
        checkOutput("rst_init_done", {31'b0, init_done}, 32'h0);
        checkOutput("rst0_ready", {31'b0, ready0}, 32'h0);

        // Sweep with reads held on cs. They must all be dropped.
        cs = 1'b1; rw = 1'b1; addr = 4'd5;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checkOutput($sformatf("sweep_ready_e%0d", k), {31'b0, ready},
                        (k == 16) ? 32'h1 : 32'h0);
            checkOutput($sformatf("sweep_rvalid_e%0d", k), {31'b0, rvalid}, 32'h0);
        end
        cs = 1'b0;
        checkOutput("sweep_init_done", {31'b0, init_done}, 32'h1);
        model_ready = 1'b1;

        // The sweep must have cleared every word.
        for (int i = 0; i < 16; i++) applyStimulus(1, 1, 4'(i), 16'h0, 2'b00);
        repeat (3) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);

        // Full write, then read on the next cycle.
        applyStimulus(1, 0, 4'd7, 16'h343A, 2'b11);
        applyStimulus(1, 1, 4'd7, 16'h0000, 2'b00);
        repeat (3) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);

        // Lane mask, then an all-zero mask as a no-op.
        applyStimulus(1, 0, 4'd7, 16'hFFFF, 2'b10);
        applyStimulus(1, 1, 4'd7, 16'h0000, 2'b11);
        applyStimulus(1, 0, 4'd7, 16'h1234, 2'b00);
        applyStimulus(1, 1, 4'd7, 16'h0000, 2'b00);
        repeat (3) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);
        checkOutput("mask_model", {16'b0, model_mem[7]}, 32'hFF3A);

        // Streaming reads; rdata then holds through idle cycles and a write.
        applyStimulus(1, 0, 4'd1, 16'h1111, 2'b11);
        applyStimulus(1, 0, 4'd2, 16'h2222, 2'b11);
        applyStimulus(1, 0, 4'd3, 16'h3333, 2'b11);
        applyStimulus(1, 1, 4'd1, 16'h0, 2'b00);
        applyStimulus(1, 1, 4'd2, 16'h0, 2'b00);
        applyStimulus(1, 1, 4'd3, 16'h0, 2'b00);
        repeat (4) applyStimulus(0, 1, 4'd9, 16'h0, 2'b00);
        checkOutput("rdata_hold_idle", {16'b0, rdata}, 32'h3333);
        applyStimulus(1, 0, 4'd4, 16'hABCD, 2'b11);
        repeat (2) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);
        checkOutput("rdata_hold_write", {16'b0, rdata}, 32'h3333);

        // Random mix of masked writes and reads against the model.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          16'($urandom), 2'($urandom_range(0, 3)));
        end
        repeat (3) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);
        checkOutput("sb_drained_run", sb.size(), 32'h0);

        // Reset right after a read is accepted. The read must never complete.
        cs = 1'b1; rw = 1'b1; addr = 4'd7;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        cs    = 1'b0;
        #1;
        checkOutput("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        checkOutput("midrst_rdata", {16'b0, rdata}, 32'h0);
        checkOutput("midrst_ready", {31'b0, ready}, 32'h0);
        checkOutput("midrst_init_done", {31'b0, init_done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_rvalid_held", {31'b0, rvalid}, 32'h0);
        model_ready = 1'b0;
        for (int i = 0; i < 16; i++) model_mem[i] = 16'h0000;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k >= 15) begin
                checkOutput($sformatf("resweep_ready_e%0d", k), {31'b0, ready},
                            (k == 16) ? 32'h1 : 32'h0);
            end
        end
        model_ready = 1'b1;
        applyStimulus(1, 1, 4'd7, 16'h0, 2'b00);
        repeat (3) applyStimulus(0, 0, 4'd0, 16'h0, 2'b00);
        checkOutput("sb_drained_resweep", sb.size(), 32'h0);

        // Build with INIT_EN=0: ready after the first edge, then write and read.
        rst0_n = 1'b1;
        @(negedge clk);
        checkOutput("noinit_ready", {31'b0, ready0}, 32'h1);
        checkOutput("noinit_init_done", {31'b0, init_done0}, 32'h1);
        cs0 = 1'b1; rw0 = 1'b0; addr0 = 4'd3; wdata0 = 16'hBEEF; be0 = 2'b11;
        @(negedge clk);
        rw0 = 1'b1; be0 = 2'b00; wdata0 = 16'h0000;
        @(negedge clk);
        cs0 = 1'b0;
        checkOutput("noinit_rvalid_early", {31'b0, rvalid0}, 32'h0);
        @(negedge clk);
        checkOutput("noinit_rvalid", {31'b0, rvalid0}, 32'h1);
        checkOutput("noinit_rdata", {16'b0, rdata0}, 32'hBEEF);
        @(negedge clk);
        checkOutput("noinit_rvalid_pulse", {31'b0, rvalid0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
